frame_mem_arbiter: RTL and testbench

Single-port arbiter for the processed-image frame RAM (65536 x 8, synchronous read). It shares the RAM between two requesters. The display path is the pixel address generator feeding VGA; it never stalls. The processing-core path issues reads and writes and uses a req/gnt handshake. The arbiter registers the winning access onto the RAM port and returns read data to the correct requester, tagged and in order.

---
 rtl/frame_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_frame_mem_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_mem_arbiter.sv
// Single-port arbiter for the processed-image frame RAM.
// Display reads have fixed priority over core reads/writes; read data is
// routed back to its requester through a tag pipeline matched to RAM latency.
module frame_mem_arbiter #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               disp_req,
    input  logic [ADDR_W-1:0]  disp_addr,
    output logic [DATA_W-1:0]  disp_rdata,
    output logic               disp_rvalid,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic               cpu_gnt,
    output logic [DATA_W-1:0]  cpu_rdata,
    output logic               cpu_rvalid,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic [STALL_W-1:0] stall_cnt
);

    localparam int unsigned TAG_W = 2;
    localparam logic [TAG_W-1:0] TAG_NONE = 2'd0;
    localparam logic [TAG_W-1:0] TAG_DISP = 2'd1;
    localparam logic [TAG_W-1:0] TAG_CPU  = 2'd2;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_DISP,
        SLOT_CPU_RD,
        SLOT_CPU_WR
    } slot_e;

    slot_e              slot_c;

    logic [ADDR_W-1:0]  mem_addr_q,  mem_addr_d;
    logic               mem_we_q,    mem_we_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [TAG_W-1:0]   tag_d;
    logic [TAG_W-1:0]   tag_q [0:RD_LAT];
    logic [TAG_W-1:0]   ret_tag;

    logic               disp_rvalid_q, disp_rvalid_d;
    logic [DATA_W-1:0]  disp_rdata_q,  disp_rdata_d;
    logic               cpu_rvalid_q,  cpu_rvalid_d;
    logic [DATA_W-1:0]  cpu_rdata_q,   cpu_rdata_d;
    logic [STALL_W-1:0] stall_q,       stall_d;
    logic               stall_inc;

    // Fixed-priority slot decision: display first, then core.
    always_comb begin
        slot_c = SLOT_IDLE;
        if (disp_req) begin
            slot_c = SLOT_DISP;
        end else if (cpu_req) begin
            slot_c = cpu_we ? SLOT_CPU_WR : SLOT_CPU_RD;
        end
    end

    assign cpu_gnt   = cpu_req & ~disp_req & ~rst;
    assign stall_inc = cpu_req & ~cpu_gnt;

    // Issue-stage next values; IDLE holds address and write data.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        tag_d       = TAG_NONE;
        case (slot_c)
            SLOT_DISP: begin
                mem_addr_d = disp_addr;
                tag_d      = TAG_DISP;
            end
            SLOT_CPU_RD: begin
                mem_addr_d = cpu_addr;
                tag_d      = TAG_CPU;
            end
            SLOT_CPU_WR: begin
                mem_addr_d  = cpu_addr;
                mem_we_d    = 1'b1;
                mem_wdata_d = cpu_wdata;
            end
            default: ;
        endcase
    end

    assign ret_tag = tag_q[RD_LAT];

    // Return-stage next values; data holds between valid pulses.
    always_comb begin
        disp_rvalid_d = 1'b0;
        disp_rdata_d  = disp_rdata_q;
        cpu_rvalid_d  = 1'b0;
        cpu_rdata_d   = cpu_rdata_q;
        if (ret_tag == TAG_DISP) begin
            disp_rvalid_d = 1'b1;
            disp_rdata_d  = mem_rdata;
        end else if (ret_tag == TAG_CPU) begin
            cpu_rvalid_d = 1'b1;
            cpu_rdata_d  = mem_rdata;
        end
    end

    // Saturating stall counter next value.
    always_comb begin
        stall_d = stall_q;
        if (stall_inc && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    // Issue registers and tag pipeline; reset drops in-flight reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            for (int i = 0; i <= int'(RD_LAT); i++) begin
                tag_q[i] <= TAG_NONE;
            end
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            tag_q[0]    <= tag_d;
            for (int i = 1; i <= int'(RD_LAT); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Return registers and stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_rvalid_q <= 1'b0;
            disp_rdata_q  <= '0;
            cpu_rvalid_q  <= 1'b0;
            cpu_rdata_q   <= '0;
            stall_q       <= '0;
        end else begin
            disp_rvalid_q <= disp_rvalid_d;
            disp_rdata_q  <= disp_rdata_d;
            cpu_rvalid_q  <= cpu_rvalid_d;
            cpu_rdata_q   <= cpu_rdata_d;
            stall_q       <= stall_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign disp_rvalid = disp_rvalid_q;
    assign disp_rdata  = disp_rdata_q;
    assign cpu_rvalid  = cpu_rvalid_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Directed bench for frame_mem_arbiter with a synchronous 64Kx8 RAM model.
module tb_frame_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        disp_req = 1'b0;
    logic [15:0] disp_addr = '0;
    logic [7:0]  disp_rdata;
    logic        disp_rvalid;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_gnt;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic [15:0] stall_cnt;

    logic [7:0]  s_disp_rdata, s_cpu_rdata, s_mem_wdata;
    logic        s_disp_rvalid, s_cpu_gnt, s_cpu_rvalid, s_mem_we;
    logic [15:0] s_mem_addr;
    logic [3:0]  s_stall_cnt;

    int asserts  = 0;
    int failures = 0;

    logic [7:0] ram [0:65535];

    always #5 clk = ~clk;

    frame_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LAT(1), .STALL_W(16)) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
    );

    frame_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LAT(1), .STALL_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_rdata(s_disp_rdata), .disp_rvalid(s_disp_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(s_cpu_gnt),
        .cpu_rdata(s_cpu_rdata), .cpu_rvalid(s_cpu_rvalid),
        .mem_addr(s_mem_addr), .mem_we(s_mem_we), .mem_wdata(s_mem_wdata),
        .mem_rdata(mem_rdata), .stall_cnt(s_stall_cnt)
    );

    // Synchronous single-port RAM, read latency 1.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        disp_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        asserts++;
        if (mem_addr !== 16'h0 || mem_we !== 1'b0 || stall_cnt !== 16'h0 ||
            disp_rvalid !== 1'b0 || cpu_rvalid !== 1'b0 || cpu_gnt !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: addr=%h we=%b stall=%0d drv=%b crv=%b gnt=%b expected all zero",
                     mem_addr, mem_we, stall_cnt, disp_rvalid, cpu_rvalid, cpu_gnt);
        end
        next_cycle();
        disp_req = 1'b1; disp_addr = 16'hBEEF;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0011;
        next_cycle();
        drive_idle();
        @(negedge clk);
        asserts++;
        if (mem_addr !== 16'hBEEF || stall_cnt !== 16'd1) begin
            failures++;
            $display("FAIL pre_reset: addr=%h stall=%0d expected BEEF 1", mem_addr, stall_cnt);
        end
        next_cycle();
        #2;
        rst = 1'b1; cpu_req = 1'b1;
        #1;
        asserts++;
        if (mem_addr !== 16'h0 || mem_we !== 1'b0 || mem_wdata !== 8'h0 ||
            disp_rvalid !== 1'b0 || cpu_rvalid !== 1'b0 || disp_rdata !== 8'h0 ||
            cpu_rdata !== 8'h0 || stall_cnt !== 16'h0 || cpu_gnt !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: addr=%h we=%b wd=%h drv=%b crv=%b dd=%h cd=%h stall=%0d gnt=%b expected all zero",
                     mem_addr, mem_we, mem_wdata, disp_rvalid, cpu_rvalid, disp_rdata,
                     cpu_rdata, stall_cnt, cpu_gnt);
        end
        cpu_req = 1'b0;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            asserts++;
            if (disp_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL reset_drop_disp: cycle %0d disp_rvalid=%b expected 0", c, disp_rvalid);
            end
            next_cycle();
        end
    endtask

    task automatic test_display_reads();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            if (c < 4) begin
                disp_req = 1'b1; disp_addr = 16'(c);
            end else begin
                drive_idle();
            end
            @(negedge clk);
            asserts++;
            if (disp_rvalid !== (c >= 3 && c <= 6)) begin
                failures++;
                $display("FAIL disp_rvalid: cycle %0d got %b expected %b", c, disp_rvalid, (c >= 3 && c <= 6));
            end else if (disp_rvalid) begin
                asserts++;
                if (disp_rdata !== 8'(c - 3)) begin
                    failures++;
                    $display("FAIL disp_rdata: cycle %0d got %h expected %h", c, disp_rdata, 8'(c - 3));
                end
            end
            asserts++;
            if (cpu_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL disp_cpu_rvalid: cycle %0d got %b expected 0", c, cpu_rvalid);
            end
            next_cycle();
        end
    endtask

    task automatic test_core_write_read();
        int we_pulses;
        we_pulses = 0;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            if (c == 0) begin
                cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'hA5;
            end else if (c == 1) begin
                cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
            end else begin
                drive_idle();
            end
            @(negedge clk);
            if (c < 2) begin
                asserts++;
                if (cpu_gnt !== 1'b1) begin
                    failures++;
                    $display("FAIL wr_rd_gnt: cycle %0d got %b expected 1", c, cpu_gnt);
                end
            end
            if (mem_we) we_pulses++;
            if (c == 1) begin
                asserts++;
                if (mem_we !== 1'b1 || mem_addr !== 16'h1234 || mem_wdata !== 8'hA5) begin
                    failures++;
                    $display("FAIL write_issue: we=%b addr=%h wdata=%h expected 1 1234 a5",
                             mem_we, mem_addr, mem_wdata);
                end
            end
            asserts++;
            if (cpu_rvalid !== (c == 4)) begin
                failures++;
                $display("FAIL wr_rd_rvalid: cycle %0d got %b expected %b", c, cpu_rvalid, (c == 4));
            end else if (c == 4) begin
                asserts++;
                if (cpu_rdata !== 8'hA5) begin
                    failures++;
                    $display("FAIL wr_rd_data: got %h expected a5", cpu_rdata);
                end
            end
            next_cycle();
        end
        asserts++;
        if (we_pulses != 1) begin
            failures++;
            $display("FAIL we_pulses: got %0d expected 1", we_pulses);
        end
    endtask

    task automatic test_contention();
        do_reset();
        for (int c = 0; c < 11; c++) begin
            if (c < 5) begin
                disp_req = 1'b1; disp_addr = 16'h0020 + 16'(c);
                cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
            end else if (c == 5) begin
                disp_req = 1'b0;
            end else begin
                drive_idle();
            end
            @(negedge clk);
            if (c <= 5) begin
                asserts++;
                if (cpu_gnt !== (c == 5)) begin
                    failures++;
                    $display("FAIL cont_gnt: cycle %0d got %b expected %b", c, cpu_gnt, (c == 5));
                end
            end
            asserts++;
            if (stall_cnt !== 16'((c < 5) ? c : 5)) begin
                failures++;
                $display("FAIL cont_stall: cycle %0d got %0d expected %0d", c, stall_cnt, (c < 5) ? c : 5);
            end
            asserts++;
            if (disp_rvalid !== (c >= 3 && c <= 7)) begin
                failures++;
                $display("FAIL cont_disp_rvalid: cycle %0d got %b expected %b", c, disp_rvalid, (c >= 3 && c <= 7));
            end else if (disp_rvalid && disp_rdata !== 8'(8'h20 + c - 3)) begin
                failures++;
                $display("FAIL cont_disp_data: cycle %0d got %h expected %h", c, disp_rdata, 8'(8'h20 + c - 3));
            end
            asserts++;
            if (cpu_rvalid !== (c == 8)) begin
                failures++;
                $display("FAIL cont_cpu_rvalid: cycle %0d got %b expected %b", c, cpu_rvalid, (c == 8));
            end else if (cpu_rvalid && cpu_rdata !== 8'h10) begin
                failures++;
                $display("FAIL cont_cpu_data: got %h expected 10", cpu_rdata);
            end
            next_cycle();
        end
    endtask

    task automatic test_interleave();
        int j, nd, nc, k;
        logic exp_d, exp_c;
        j = 0; nd = 0; nc = 0;
        do_reset();
        for (int c = 0; c < 70; c++) begin
            if (c < 64) begin
                disp_req = (c % 2 == 0); disp_addr = 16'h0100 + 16'(c / 2);
                cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0200 + 16'(j);
            end else begin
                drive_idle();
            end
            @(negedge clk);
            asserts++;
            if (cpu_gnt !== (c < 64 && c % 2 == 1)) begin
                failures++;
                $display("FAIL il_gnt: cycle %0d got %b", c, cpu_gnt);
            end
            k = (c - 3) / 2;
            exp_d = (c >= 3 && c < 67 && (c - 3) % 2 == 0);
            exp_c = (c >= 3 && c < 67 && (c - 3) % 2 == 1);
            if (disp_rvalid) nd++;
            if (cpu_rvalid) nc++;
            asserts++;
            if (disp_rvalid !== exp_d || cpu_rvalid !== exp_c) begin
                failures++;
                $display("FAIL il_route: cycle %0d drv=%b crv=%b expected %b %b", c, disp_rvalid, cpu_rvalid, exp_d, exp_c);
            end else if ((exp_d && disp_rdata !== 8'(k)) || (exp_c && cpu_rdata !== 8'(k))) begin
                failures++;
                $display("FAIL il_data: cycle %0d dd=%h cd=%h expected %h", c, disp_rdata, cpu_rdata, 8'(k));
            end
            if (c < 64 && c % 2 == 1) j++;
            next_cycle();
        end
        asserts++;
        if (nd != 32 || nc != 32) begin
            failures++;
            $display("FAIL il_count: disp=%0d cpu=%0d expected 32 32", nd, nc);
        end
    endtask

    task automatic test_reset_in_flight();
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0050;
        @(negedge clk);
        asserts++;
        if (cpu_gnt !== 1'b1) begin
            failures++;
            $display("FAIL rif_gnt: got %b expected 1", cpu_gnt);
        end
        next_cycle();
        drive_idle();
        #2;
        rst = 1'b1; cpu_req = 1'b1;
        #1;
        asserts++;
        if (cpu_gnt !== 1'b0) begin
            failures++;
            $display("FAIL rif_gnt_in_reset: got %b expected 0", cpu_gnt);
        end
        cpu_req = 1'b0;
        #3;
        rst = 1'b0;
        next_cycle();
        for (int c = 2; c < 8; c++) begin
            @(negedge clk);
            asserts++;
            if (cpu_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL rif_rvalid: cycle %0d got %b expected 0", c, cpu_rvalid);
            end
            next_cycle();
        end
    endtask

    task automatic test_stall_saturation();
        do_reset();
        for (int c = 0; c < 23; c++) begin
            if (c < 20) begin
                disp_req = 1'b1; disp_addr = 16'hFFFF;
                cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFFFF;
            end else begin
                drive_idle();
            end
            @(negedge clk);
            asserts++;
            if (s_stall_cnt !== 4'((c < 15) ? c : 15)) begin
                failures++;
                $display("FAIL sat_stall4: cycle %0d got %0d expected %0d", c, s_stall_cnt, (c < 15) ? c : 15);
            end
            asserts++;
            if (stall_cnt !== 16'((c < 20) ? c : 20)) begin
                failures++;
                $display("FAIL sat_stall16: cycle %0d got %0d expected %0d", c, stall_cnt, (c < 20) ? c : 20);
            end
            if (c == 3) begin
                asserts++;
                if (disp_rvalid !== 1'b1 || disp_rdata !== 8'hFF) begin
                    failures++;
                    $display("FAIL addr_ffff: rvalid=%b data=%h expected 1 ff", disp_rvalid, disp_rdata);
                end
            end
            next_cycle();
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'(i);
        test_reset();
        test_display_reads();
        test_core_write_read();
        test_contention();
        test_interleave();
        test_reset_in_flight();
        test_stall_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
